vga_timing_ctrl: RTL

- Sequences the pixel datapath feeding the HDMI/VGA output stage.
- Runs parameterised horizontal and vertical counters (720p defaults) and generates hsync, vsync and de.
- Pulls pixels from an upstream source with a ready/valid handshake, one cycle ahead of de.
- Substitutes black and flags underflow when the source is late.
- Controls frame start/stop so upstream blocks (carplate overlay, frame reader) stay frame-aligned.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_timing_counter.sv | 60 ++++++
 rtl/vga_timing_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants, FSM state encoding and pixel type for the VGA/HDMI
// timing controller and its counter.
package vga_pkg;

  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;

  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOT_720P = timing_total(H_ACTIVE_720P, H_FP_720P, H_SYNC_720P, H_BP_720P);
  localparam int V_TOT_720P = timing_total(V_ACTIVE_720P, V_FP_720P, V_SYNC_720P, V_BP_720P);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical raster counters with active-region and sync-window decode.
// Counters are held at (0,0) while clear is high.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720P,
  parameter int H_FP     = H_FP_720P,
  parameter int H_SYNC   = H_SYNC_720P,
  parameter int H_BP     = H_BP_720P,
  parameter int V_ACTIVE = V_ACTIVE_720P,
  parameter int V_FP     = V_FP_720P,
  parameter int V_SYNC   = V_SYNC_720P,
  parameter int V_BP     = V_BP_720P,
  localparam int H_TOT   = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOT   = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = $clog2(H_TOT),
  localparam int VW      = $clog2(V_TOT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active,
  output logic          hs_win,
  output logic          vs_win,
  output logic          frame_end
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic line_end;

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_win = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_win = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

endmodule

// File: rtl/vga_timing_ctrl.sv
// Pixel-path sequencer: frame-aligned run/drain FSM, one-cycle-ahead pixel pull
// from the source, registered RGB/de/sync outputs and sticky underflow flag.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720P,
  parameter int H_FP     = H_FP_720P,
  parameter int H_SYNC   = H_SYNC_720P,
  parameter int H_BP     = H_BP_720P,
  parameter int V_ACTIVE = V_ACTIVE_720P,
  parameter int V_FP     = V_FP_720P,
  parameter int V_SYNC   = V_SYNC_720P,
  parameter int V_BP     = V_BP_720P,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  localparam int H_TOT   = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOT   = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = $clog2(H_TOT),
  localparam int VW      = $clog2(V_TOT)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        frame_start,
  output logic        line_start,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        underflow,
  output logic        busy
);

  state_t        state, state_n;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          active, hs_win, vs_win, frame_end;
  pixel_t        pix_in, pix_out;

  vga_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == IDLE),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .active    (active),
    .hs_win    (hs_win),
    .vs_win    (vs_win),
    .frame_end (frame_end)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // en only takes effect at a frame boundary; a stop request always completes
  // the frame in progress, and a stop on the last cycle goes straight to IDLE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (en) state_n = RUN;
      RUN:     if (!en) state_n = frame_end ? IDLE : DRAIN;
      DRAIN:   if (frame_end) state_n = en ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Stage 0: handshake and alignment pulses, decoded from the live counters.
  assign busy        = (state != IDLE);
  assign pix_ready   = active && busy;
  assign line_start  = pix_ready && (h_cnt == '0);
  assign frame_start = line_start && (v_cnt == '0);
  assign pix_in      = pix_data;

  // Stage 1: a late source yields black; timing never waits for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      de        <= 1'b0;
      hsync     <= ~HS_POL;
      vsync     <= ~VS_POL;
      pix_out   <= '0;
      underflow <= 1'b0;
    end else begin
      de      <= pix_ready;
      hsync   <= hs_win ? HS_POL : ~HS_POL;
      vsync   <= vs_win ? VS_POL : ~VS_POL;
      pix_out <= (pix_ready && pix_valid) ? pix_in : '0;
      if (pix_ready && !pix_valid) underflow <= 1'b1;
    end
  end

  assign r = pix_out.r;
  assign g = pix_out.g;
  assign b = pix_out.b;

endmodule
